pad_activity_monitor: RTL and testbench

//  Synthesizable multi-channel activity/stuck-at monitor for pad-level signals (sys_clk_o, io_padN).

---
 rtl/pad_mon_pkg.sv | 18 +
 rtl/pad_act_chan.sv | 83 ++++++++
 rtl/pad_activity_monitor.sv | 113 +++++++++++
 tb/tb_pad_activity_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_mon_pkg.sv
// Shared types and helpers for the pad activity monitor.
// Window-length-dependent widths are derived in the top from its own parameters.
package pad_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EVAL
  } mon_state_t;

  localparam int unsigned DEF_WINDOW_CYCLES = 1024;
  localparam int unsigned WIN_W             = $clog2(DEF_WINDOW_CYCLES);

  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/pad_act_chan.sv
// One monitored channel: synchronizer, edge detect, saturating toggle counter,
// published snapshot/activity and sticky stuck-at flags.
module pad_act_chan
  import pad_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_TOGGLES = 2
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             ch_i,
  input  logic             i_idle,
  input  logic             i_count_en,
  input  logic             i_eval,
  input  logic             i_carry,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_snap,
  output logic             o_active_nxt,
  output logic             o_active,
  output logic             o_stuck_lo,
  output logic             o_stuck_hi
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_lvl;
  logic                   w_tog;

  assign w_lvl        = r_sync[SYNC_STAGES-1];
  assign w_tog        = w_lvl ^ r_prev;
  assign o_active_nxt = (32'(r_cnt) >= MIN_TOGGLES);

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ch_i};
      r_prev <= w_lvl;
    end
  end

  // The edge seen during EVAL seeds the next window so boundary toggles are never lost.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_cnt <= '0;
    end else if (i_eval) begin
      r_cnt <= (i_carry && w_tog) ? CNT_W'(1) : '0;
    end else if (i_idle) begin
      r_cnt <= '0;
    end else if (i_count_en && w_tog && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      o_snap   <= '0;
      o_active <= 1'b0;
    end else if (i_eval) begin
      o_snap   <= r_cnt;
      o_active <= o_active_nxt;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      o_stuck_lo <= 1'b0;
      o_stuck_hi <= 1'b0;
    end else if (i_clear) begin
      o_stuck_lo <= 1'b0;
      o_stuck_hi <= 1'b0;
    end else if (i_eval && (r_cnt == '0)) begin
      o_stuck_lo <= o_stuck_lo | ~w_lvl;
      o_stuck_hi <= o_stuck_hi | w_lvl;
    end
  end

endmodule

// File: rtl/pad_activity_monitor.sv
// Multi-channel pad activity / stuck-at monitor: window FSM, fault counter and
// count readback around an array of per-channel monitors.
module pad_activity_monitor
  import pad_mon_pkg::*;
#(
  parameter int unsigned NUM_CH        = 8,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned MIN_TOGGLES   = 2
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic [NUM_CH-1:0]         ch_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [$clog2(NUM_CH)-1:0] rd_sel_i,
  output logic [CNT_W-1:0]          rd_cnt_o,
  output logic [NUM_CH-1:0]         active_o,
  output logic [NUM_CH-1:0]         stuck_lo_o,
  output logic [NUM_CH-1:0]         stuck_hi_o,
  output logic                      window_done_o,
  output logic                      fault_o,
  output logic [7:0]                fault_cnt_o
);

  localparam int unsigned      WIN_BITS = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_BITS-1:0] WIN_LAST = WIN_BITS'(WINDOW_CYCLES - 1);

  mon_state_t        r_state;
  mon_state_t        w_next;
  logic [WIN_BITS-1:0] r_win;
  logic              r_first;
  logic              r_done;
  logic [7:0]        r_fault_cnt;
  logic              w_idle;
  logic              w_eval;
  logic              w_count_en;
  logic              w_carry;
  logic [NUM_CH-1:0] w_active_nxt;
  logic [CNT_W-1:0]  w_snap [NUM_CH];

  assign w_idle      = (r_state == IDLE);
  assign w_eval      = (r_state == EVAL);
  // First RUN cycle after IDLE only primes the edge detector.
  assign w_count_en  = (r_state == RUN) && !r_first;
  assign w_carry     = w_eval && enable_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_next = RUN;
      RUN: begin
        if (!enable_i)             w_next = IDLE;
        else if (r_win == WIN_LAST) w_next = EVAL;
      end
      EVAL:    w_next = enable_i ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      r_state     <= IDLE;
      r_win       <= '0;
      r_first     <= 1'b0;
      r_done      <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_win   <= (r_state == RUN) ? r_win + 1'b1 : '0;
      r_first <= w_idle;
      r_done  <= w_eval;
      if (clear_i) begin
        r_fault_cnt <= '0;
      end else if (w_eval && !(&w_active_nxt) && (r_fault_cnt != 8'hFF)) begin
        r_fault_cnt <= r_fault_cnt + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    pad_act_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .MIN_TOGGLES (MIN_TOGGLES)
    ) u_chan (
      .sys_clk_i    (sys_clk_i),
      .sys_rst_i    (sys_rst_i),
      .ch_i         (ch_i[g]),
      .i_idle       (w_idle),
      .i_count_en   (w_count_en),
      .i_eval       (w_eval),
      .i_carry      (w_carry),
      .i_clear      (clear_i),
      .o_snap       (w_snap[g]),
      .o_active_nxt (w_active_nxt[g]),
      .o_active     (active_o[g]),
      .o_stuck_lo   (stuck_lo_o[g]),
      .o_stuck_hi   (stuck_hi_o[g])
    );
  end

  always_comb begin
    rd_cnt_o = '0;
    if (32'(rd_sel_i) < NUM_CH) rd_cnt_o = w_snap[rd_sel_i];
  end

  assign window_done_o = r_done;
  assign fault_cnt_o   = r_fault_cnt;
  assign fault_o       = |(stuck_lo_o | stuck_hi_o);

endmodule

// File: tb/tb_pad_activity_monitor.sv
// Randomised and directed bench for pad_activity_monitor against a window-level
// behavioural model (pad history queue, per-window toggle tallies).
module tb_pad_activity_monitor;

  localparam int NCH  = 4;
  localparam int W    = 16;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int MT   = 2;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch;
  logic       en;
  logic       clr;
  logic [1:0] sel;
  logic [3:0] rd_cnt_o;
  logic [3:0] active_o, stuck_lo_o, stuck_hi_o;
  logic       window_done_o, fault_o;
  logic [7:0] fault_cnt_o;

  pad_activity_monitor #(
    .NUM_CH        (NCH),
    .WINDOW_CYCLES (W),
    .CNT_W         (CW),
    .SYNC_STAGES   (SS),
    .MIN_TOGGLES   (MT)
  ) dut (
    .sys_clk_i     (clk),
    .sys_rst_i     (rst),
    .ch_i          (ch),
    .enable_i      (en),
    .clear_i       (clr),
    .rd_sel_i      (sel),
    .rd_cnt_o      (rd_cnt_o),
    .active_o      (active_o),
    .stuck_lo_o    (stuck_lo_o),
    .stuck_hi_o    (stuck_hi_o),
    .window_done_o (window_done_o),
    .fault_o       (fault_o),
    .fault_cnt_o   (fault_cnt_o)
  );

  always #5 clk = ~clk;

  // Model: m_pos = -1 idle, 0..W-1 position in window, W = evaluation cycle.
  int         m_pos;
  bit         m_first;
  int         m_cnt  [NCH];
  int         m_snap [NCH];
  logic [3:0] m_act, m_slo, m_shi;
  bit         m_done;
  int         m_fault;
  logic [3:0] hist [$];

  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  logic [3:0] pat = '0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] hv(input int k);
    int idx;
    idx = hist.size() - 1 - k;
    return (idx >= 0) ? hist[idx] : 4'b0000;
  endfunction

  task automatic model_reset();
    m_pos = -1; m_first = 1'b0; m_done = 1'b0; m_fault = 0;
    m_act = '0; m_slo = '0; m_shi = '0;
    for (int i = 0; i < NCH; i++) begin m_cnt[i] = 0; m_snap[i] = 0; end
    hist.delete();
  endtask

  task automatic model_step();
    logic [3:0] lvl, tog;
    bit any_off;
    hist.push_back(ch);
    if (hist.size() > 8) void'(hist.pop_front());
    lvl = hv(SS);
    tog = lvl ^ hv(SS + 1);
    m_done = 1'b0;
    if (m_pos < 0) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      if (en) begin m_pos = 0; m_first = 1'b1; end
    end else if (m_pos < W) begin
      if (!en) begin
        m_pos = -1;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end else begin
        if (!m_first)
          for (int i = 0; i < NCH; i++)
            if (tog[i] && m_cnt[i] < CMAX) m_cnt[i]++;
        m_first = 1'b0;
        m_pos++;
      end
    end else begin
      any_off = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_snap[i] = m_cnt[i];
        m_act[i]  = (m_cnt[i] >= MT);
        if (!m_act[i]) any_off = 1'b1;
        if (m_cnt[i] == 0) begin
          if (lvl[i]) m_shi[i] = 1'b1; else m_slo[i] = 1'b1;
        end
        m_cnt[i] = (en && tog[i]) ? 1 : 0;
      end
      if (any_off && m_fault < 255) m_fault++;
      m_done  = 1'b1;
      m_pos   = en ? 0 : -1;
      m_first = 1'b0;
    end
    if (clr) begin m_slo = '0; m_shi = '0; m_fault = 0; end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      check("window_done", int'(window_done_o), int'(m_done));
      check("active",      int'(active_o),      int'(m_act));
      check("stuck_lo",    int'(stuck_lo_o),    int'(m_slo));
      check("stuck_hi",    int'(stuck_hi_o),    int'(m_shi));
      check("fault",       int'(fault_o),       int'(|(m_slo | m_shi)));
      check("fault_cnt",   int'(fault_cnt_o),   m_fault);
      check("rd_cnt",      int'(rd_cnt_o),      m_snap[sel]);
    end
  end

  task automatic step(input logic [3:0] c, input logic e, input logic cl, input logic [1:0] s);
    @(negedge clk);
    ch = c; en = e; clr = cl; sel = s;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_window(input logic [3:0] hold, input logic [3:0] tmask,
                            input bit clr_eval, input logic [1:0] s, output int steps);
    bit seen;
    seen  = 1'b0;
    steps = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      pat = pat ^ tmask;
      step((hold & ~tmask) | (pat & tmask), 1'b1, clr_eval && (m_pos == W), s);
      steps++;
      if (window_done_o) seen = 1'b1;
    end
    if (!seen) check("window_timeout", 0, 1);
  endtask

  initial begin
    int k, sum_a, sum_b;
    logic [3:0] act_keep, rd_keep;
    bit done_seen;

    rst = 1'b1; ch = '0; en = 1'b0; clr = 1'b0; sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_active",    int'(active_o), 0);
    check("reset_stuck",     int'(stuck_lo_o | stuck_hi_o), 0);
    check("reset_done",      int'(window_done_o), 0);
    check("reset_fault_cnt", int'(fault_cnt_o), 0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // ch0 toggles every cycle, others held low
    run_window(4'b0000, 4'b0001, 1'b0, 2'd0, k);
    check("t1_latency", k, 18);
    check("t1_active",   int'(active_o), 4'b0001);
    check("t1_stuck_lo", int'(stuck_lo_o), 4'b1110);
    check("t1_fault_cnt", int'(fault_cnt_o), 1);
    check("t1_rd_cnt0",  int'(rd_cnt_o), 15);
    // Second window would hold 17 edges: saturate, not wrap
    run_window(4'b0000, 4'b0001, 1'b0, 2'd0, k);
    check("t3_sat_rd_cnt0", int'(rd_cnt_o), 15);
    check("t3_period", k, 17);

    // ch2 held high across two windows, then toggled
    run_window(4'b0100, 4'b0001, 1'b0, 2'd2, k);
    run_window(4'b0100, 4'b0001, 1'b0, 2'd2, k);
    check("t2_stuck_hi2", int'(stuck_hi_o[2]), 1);
    run_window(4'b0000, 4'b0101, 1'b0, 2'd2, k);
    check("t2_active2",       int'(active_o[2]), 1);
    check("t2_stuck_hi2_keep", int'(stuck_hi_o[2]), 1);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] c;
      c = pat;
      c[0] = 1'($urandom);
      if ($urandom_range(0, 9) == 0) c[1] = ~c[1];
      if ($urandom_range(0, 39) == 0) c[2] = ~c[2];
      if ($urandom_range(0, 99) == 0) c[3] = ~c[3];
      pat = c;
      step(c, ($urandom_range(0, 79) != 0), ($urandom_range(0, 59) == 0),
           2'($urandom_range(0, 3)));
    end

    // Abort mid-window: published results held, no pulse
    run_window(4'b0000, 4'b0011, 1'b0, 2'd1, k);
    for (int i = 0; i < 40 && m_pos != 8; i++) step(pat, 1'b1, 1'b0, 2'd1);
    act_keep  = active_o;
    rd_keep   = rd_cnt_o;
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(pat, 1'b0, 1'b0, 2'd1);
      if (window_done_o) done_seen = 1'b1;
    end
    check("t4_no_done",   int'(done_seen), 0);
    check("t4_active_kept", int'(active_o), int'(act_keep));
    check("t4_rd_kept",   int'(rd_cnt_o), int'(rd_keep));
    run_window(4'b0000, 4'b0011, 1'b0, 2'd1, k);
    check("t4_relatency", k, 18);

    // Clear in the EVAL cycle with ch3 stuck low
    run_window(4'b0000, 4'b0111, 1'b1, 2'd3, k);
    check("t5_stuck_lo",  int'(stuck_lo_o), 0);
    check("t5_stuck_hi",  int'(stuck_hi_o), 0);
    check("t5_fault_cnt", int'(fault_cnt_o), 0);
    check("t5_active",    int'(active_o), 4'b0111);

    // Asynchronous reset mid-window
    for (int i = 0; i < 5; i++) step(pat, 1'b1, 1'b0, 2'd0);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_active", int'(active_o), 0);
    check("t6_rst_stuck",  int'(stuck_lo_o | stuck_hi_o), 0);
    check("t6_rst_done",   int'(window_done_o), 0);
    check("t6_rst_fault",  int'(fault_o), 0);
    check("t6_rst_fcnt",   int'(fault_cnt_o), 0);
    check("t6_rst_rd",     int'(rd_cnt_o), 0);
    #1;
    rst = 1'b0;

    // One ch1 edge landing exactly in the EVAL cycle is counted once
    pat = '0;
    run_window(4'b0000, 4'b0001, 1'b0, 2'd1, k);
    for (int i = 0; i < 40 && m_pos != W - 2; i++) begin
      pat = pat ^ 4'b0001;
      step(pat & 4'b0001, 1'b1, 1'b0, 2'd1);
    end
    pat[1] = 1'b0;
    run_window(4'b0010, 4'b0001, 1'b0, 2'd1, k);
    sum_a = int'(rd_cnt_o);
    run_window(4'b0010, 4'b0001, 1'b0, 2'd1, k);
    sum_b = int'(rd_cnt_o);
    check("t6_straddle_first", sum_a, 0);
    check("t6_straddle_sum", sum_a + sum_b, 1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
